xcorr_sched: RTL
================

XCORR_SCHED -- requirements
Module: xcorr_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of mic-pair requesters sharing one cross-correlation engine; minimum 2.
REQ-002 Parameter OUT_ADDR_WIDTH, default 8: engine lag-index width.
REQ-003 Parameter DATA_WIDTH, default 8: engine output sample width.
REQ-004 Parameter TIMEOUT, default 2^18: watchdog limit in clk cycles; minimum 2^(2*OUT_ADDR_WIDTH)+8.
REQ-005 Port clk  input  1  system clock; all logic on posedge.
REQ-006 Port reset_n  input  1  asynchronous active-low reset.
REQ-007 Port req  input  NUM_REQ  per-requester job request; level, held until its done pulse.
REQ-008 Port gnt  output  NUM_REQ  one-hot grant, high from grant through job completion.
REQ-009 Port pair_sel  output  clog2(NUM_REQ)  index of granted requester; steers engine input buffer muxes.
REQ-010 Port xc_start  output  1  start level to engine.
REQ-011 Port xc_valid  input  1  engine finished-sweep level.
REQ-012 Port xc_s_addr  input  OUT_ADDR_WIDTH  engine output lag index.
REQ-013 Port xc_s_data  input  DATA_WIDTH  engine output sum, unsigned.
REQ-014 Port xc_s_wren  input  1  engine output write strobe.
REQ-015 Port done  output  1  one-cycle job-complete pulse.
REQ-016 Port done_id  output  clog2(NUM_REQ)  requester index of completed job, held until next done.
REQ-017 Port peak_lag  output  OUT_ADDR_WIDTH  lag of maximum correlation, held until next done.
REQ-018 Port peak_val  output  DATA_WIDTH  maximum correlation value, held until next done.
REQ-019 Port err  output  1  set with done when job ended by watchdog timeout.
REQ-020 Port busy  output  1  high in any state other than IDLE.

Function
REQ-021 FSM states IDLE, GRANT, RUN, DRAIN, REPORT; one job in flight at a time.
REQ-022 IDLE: when any req bit high, pick winner round-robin starting at index last_winner+1 (mod NUM_REQ); go GRANT next cycle.
REQ-023 GRANT: gnt, pair_sel valid; peak registers cleared (peak_val_acc=0, peak_lag_acc=0, first_flag=1); watchdog cleared; go RUN.
REQ-024 RUN: xc_start=1; every cycle with xc_s_wren=1, if first_flag or xc_s_data > peak_val_acc (strict), capture xc_s_data and xc_s_addr, clear first_flag; ties keep earlier (lower) lag.
REQ-025 RUN exit: xc_valid=1 -> DRAIN; watchdog reaching TIMEOUT -> DRAIN with err_flag set.
REQ-026 DRAIN: xc_start=0; wait for xc_valid=0, then REPORT; watchdog continues, second expiry forces REPORT.
REQ-027 REPORT: done=1 one cycle; done_id, peak_lag, peak_val, err loaded from accumulators; gnt cleared; last_winner updated; go IDLE.
REQ-028 gnt, pair_sel constant for the whole GRANT..REPORT interval.
REQ-029 req deassert mid-job is ignored; job runs to completion and reports.
REQ-030 Requester whose req is still high after its done is eligible again only after all other pending requesters are served (round-robin fairness).
REQ-031 Job latency from grant to done: 2 + engine sweep cycles + drain cycles; no bubble beyond one IDLE cycle between jobs.
REQ-032 Watchdog counter width clog2(TIMEOUT)+1, saturating, never wraps.
REQ-033 Unsigned compare only; peak_val width equals DATA_WIDTH, no truncation.

Reset
REQ-034 reset_n low asynchronously forces: state IDLE, gnt=0, pair_sel=0, xc_start=0, done=0, done_id=0, peak_lag=0, peak_val=0, err=0, busy=0, last_winner=NUM_REQ-1 (so index 0 wins first).
REQ-035 Reset mid-job abandons the job with no done pulse; engine returns to its idle via xc_start=0.

Verification
REQ-036 req=4'b0001, engine model peak 0x5A at lag 37 -> gnt=0001, xc_start high until valid, done pulse, done_id=0, peak_lag=37, peak_val=0x5A, err=0.
REQ-037 req=4'b1111 held -> grants in order 0,1,2,3,0; gnt always one-hot; done_id sequence matches.
REQ-038 Equal maxima 0x40 at lags 10 and 200 -> peak_lag=10.
REQ-039 Engine never asserts xc_valid -> done after TIMEOUT+2 cycles with err=1, xc_start=0.
REQ-040 reset_n low during RUN -> all outputs at REQ-034 values immediately; no done; new req after release granted to index 0.
REQ-041 req bit 2 dropped mid-RUN -> job completes, done_id=2 reported.

Source files
------------

// File: rtl/xcorr_sched.sv
// xcorr_sched
// Shares one cross-correlation engine between NUM_REQ mic-pair requesters.
// A round-robin arbiter picks one job at a time and steers the engine input
// muxes with pair_sel. While the engine sweeps its lags, the scheduler tracks
// the largest output sample and the lag where it first occurred. When the job
// finishes it pulses done with the job's requester index, peak lag and peak
// value. A watchdog ends jobs whose engine never reports completion.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   req        per-requester job request (level, held until its done)
//   gnt        one-hot grant, high from grant through job completion
//   pair_sel   index of the granted requester
//   xc_start   start level to the engine
//   xc_valid   engine finished-sweep level
//   xc_s_addr  engine output lag index
//   xc_s_data  engine output sum (unsigned)
//   xc_s_wren  engine output write strobe
//   done       one-cycle job-complete pulse
//   done_id    requester index of the completed job
//   peak_lag   lag of the maximum correlation
//   peak_val   maximum correlation value
//   err        job was ended by the watchdog
//   busy       scheduler is not idle
module xcorr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int OUT_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT        = 2**18
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] pair_sel,
  output logic                       xc_start,
  input  logic                       xc_valid,
  input  logic [OUT_ADDR_WIDTH-1:0]  xc_s_addr,
  input  logic [DATA_WIDTH-1:0]      xc_s_data,
  input  logic                       xc_s_wren,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [OUT_ADDR_WIDTH-1:0]  peak_lag,
  output logic [DATA_WIDTH-1:0]      peak_val,
  output logic                       err,
  output logic                       busy
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int SW1   = SEL_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, GRANT, RUN, DRAIN, REPORT} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [SEL_W-1:0]          last_winner;
  logic [SEL_W-1:0]          winner;
  logic [2*NUM_REQ-1:0]      req_dbl;
  logic [NUM_REQ-1:0]        rr_rot;
  logic [SW1-1:0]            rr_start;
  logic [SW1-1:0]            rr_sum;
  logic [SEL_W-1:0]          rr_off;
  logic [DATA_WIDTH-1:0]     peak_val_acc;
  logic [OUT_ADDR_WIDTH-1:0] peak_lag_acc;
  logic                      first_flag;
  logic                      err_flag;
  logic [WD_W-1:0]           wdog;
  logic                      wd_hit;
  logic                      capture;

  assign wd_hit  = (wdog >= WD_W'(TIMEOUT - 1));
  // Strict compare: on equal values the earlier (lower) lag is kept.
  assign capture = xc_s_wren && (first_flag || (xc_s_data > peak_val_acc));

  // Round-robin pick: rotate the request vector so the requester after the
  // last winner sits at bit 0, find the lowest set bit, then rotate back.
  // Doubling req makes the rotation a plain shift.
  always_comb begin
    req_dbl  = {req, req};
    rr_start = SW1'(last_winner) + SW1'(1);
    rr_rot   = NUM_REQ'(req_dbl >> rr_start);
    rr_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (((rr_rot >> i) & NUM_REQ'(1)) != '0) rr_off = SEL_W'(i);
    end
    rr_sum = rr_start + SW1'(rr_off);
    if (rr_sum >= SW1'(NUM_REQ)) rr_sum = rr_sum - SW1'(NUM_REQ);
    winner = rr_sum[SEL_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    xc_start   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (|req) state_next = GRANT;
      GRANT:   state_next = RUN;
      RUN: begin
        xc_start = 1'b1;
        if (xc_valid || wd_hit) state_next = DRAIN;
      end
      DRAIN:   if (!xc_valid || wd_hit) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, peak tracking, watchdog and result registers. The watchdog is
  // restarted when RUN times out so DRAIN gets its own full window; a DRAIN
  // that ends with xc_valid still high was also cut short by the watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt          <= '0;
      pair_sel     <= '0;
      done         <= 1'b0;
      done_id      <= '0;
      peak_lag     <= '0;
      peak_val     <= '0;
      err          <= 1'b0;
      last_winner  <= SEL_W'(NUM_REQ - 1);
      peak_val_acc <= '0;
      peak_lag_acc <= '0;
      first_flag   <= 1'b1;
      err_flag     <= 1'b0;
      wdog         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (state_next == GRANT) begin
            gnt      <= NUM_REQ'(1) << winner;
            pair_sel <= winner;
          end
        end
        GRANT: begin
          peak_val_acc <= '0;
          peak_lag_acc <= '0;
          first_flag   <= 1'b1;
          err_flag     <= 1'b0;
          wdog         <= '0;
        end
        RUN: begin
          if (wdog < WD_W'(TIMEOUT)) wdog <= wdog + 1'b1;
          if (capture) begin
            peak_val_acc <= xc_s_data;
            peak_lag_acc <= xc_s_addr;
            first_flag   <= 1'b0;
          end
          if (!xc_valid && wd_hit) begin
            err_flag <= 1'b1;
            wdog     <= '0;
          end
        end
        DRAIN: begin
          if (wdog < WD_W'(TIMEOUT)) wdog <= wdog + 1'b1;
          if (state_next == REPORT) begin
            done     <= 1'b1;
            done_id  <= pair_sel;
            peak_lag <= peak_lag_acc;
            peak_val <= peak_val_acc;
            err      <= err_flag | xc_valid;
          end
        end
        REPORT: begin
          gnt         <= '0;
          last_winner <= pair_sel;
        end
        default: ;
      endcase
    end
  end

endmodule
